// File: rtl/register_file_2r1w_pkg.sv
// Shared types and default geometry for the two-read/one-write register file.
package register_file_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/register_file_2r1w_if.sv
// Bus bundle for register_file_2r1w: write port, two read ports, clear/busy.
interface register_file_2r1w_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int AW = $clog2(DEPTH);

    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] din;
    logic [AW-1:0]    raddr_a;
    logic [AW-1:0]    raddr_b;
    logic             clear;
    logic [WIDTH-1:0] dout_a;
    logic [WIDTH-1:0] dout_b;
    logic             busy;

    modport master (
        output we, waddr, din, raddr_a, raddr_b, clear,
        input  dout_a, dout_b, busy
    );

    modport slave (
        input  we, waddr, din, raddr_a, raddr_b, clear,
        output dout_a, dout_b, busy
    );
endinterface

// File: rtl/register_file_2r1w_clear_seq.sv
// Sequential clear engine: walks a pointer over every entry, one per cycle, while busy.
module reg_clear_seq
    import register_file_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    output logic          busy_o,
    output logic          clr_en_o,
    output logic [AW-1:0] clr_addr_o
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    clr_state_e    state_q;
    logic [AW-1:0] ptr_q;
    logic          busy_q;

    // Clear FSM: a clear request while already clearing is ignored.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clear_i) begin
                        state_q <= ST_CLEAR;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    ptr_q <= '0;
                end
                ST_CLEAR: begin
                    if (ptr_q == LAST_ADDR) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        ptr_q   <= '0;
                    end else begin
                        state_q <= ST_CLEAR;
                        busy_q  <= 1'b1;
                        ptr_q   <= ptr_q + AW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    ptr_q   <= '0;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign clr_en_o   = busy_q;
    assign clr_addr_o = ptr_q;

endmodule

// File: rtl/register_file_2r1w.sv
// DEPTH x WIDTH register file: one gated synchronous write port, two combinational
// read ports with optional same-cycle bypass and optional hardwired-zero entry 0.
module register_file_2r1w
    import register_file_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    register_file_2r1w_if.slave bus
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);
    localparam logic          ZR_EN   = (ZERO_REG != 0);
    localparam logic          BYP_EN  = (BYPASS != 0);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             busy_s;
    logic             clr_en_s;
    logic [AW-1:0]    clr_addr_s;
    logic             wr_ok_s;
    logic             rd_ok_a_s;
    logic             rd_ok_b_s;
    logic [WIDTH-1:0] dout_a_s;
    logic [WIDTH-1:0] dout_b_s;

    reg_clear_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_seq (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (bus.clear),
        .busy_o     (busy_s),
        .clr_en_o   (clr_en_s),
        .clr_addr_o (clr_addr_s)
    );

    // A clear request on the same edge beats the write, so it is neither stored nor bypassed.
    assign wr_ok_s   = bus.we && !busy_s && !bus.clear
                    && ({1'b0, bus.waddr} < DEPTH_L)
                    && !(ZR_EN && (bus.waddr == '0));
    assign rd_ok_a_s = ({1'b0, bus.raddr_a} < DEPTH_L) && !(ZR_EN && (bus.raddr_a == '0));
    assign rd_ok_b_s = ({1'b0, bus.raddr_b} < DEPTH_L) && !(ZR_EN && (bus.raddr_b == '0));

    // Storage array; the clear engine and the write port are mutually exclusive via busy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clr_en_s) begin
            mem_q[clr_addr_s] <= '0;
        end else if (wr_ok_s) begin
            mem_q[bus.waddr] <= bus.din;
        end
    end

    // Read port A with optional forwarding of the accepted write.
    always_comb begin
        dout_a_s = '0;
        if (!rd_ok_a_s) begin
            dout_a_s = '0;
        end else if (BYP_EN && wr_ok_s && (bus.waddr == bus.raddr_a)) begin
            dout_a_s = bus.din;
        end else begin
            dout_a_s = mem_q[bus.raddr_a];
        end
    end

    // Read port B, identical to port A.
    always_comb begin
        dout_b_s = '0;
        if (!rd_ok_b_s) begin
            dout_b_s = '0;
        end else if (BYP_EN && wr_ok_s && (bus.waddr == bus.raddr_b)) begin
            dout_b_s = bus.din;
        end else begin
            dout_b_s = mem_q[bus.raddr_b];
        end
    end

    assign bus.dout_a = dout_a_s;
    assign bus.dout_b = dout_b_s;
    assign bus.busy   = busy_s;

endmodule

// File: tb/tb_register_file_2r1w.sv
// Drives two register-file configurations with identical stimulus and checks them
// against an array-based reference model.
module tb_register_file_2r1w;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       we;
    logic [2:0] waddr;
    logic [7:0] din;
    logic [2:0] raddr_a;
    logic [2:0] raddr_b;
    logic       clear;

    int total = 0;
    int bad   = 0;

    // Reference model: instance 0 = DEPTH 8 / bypass / no zero reg, instance 1 = DEPTH 6 / no bypass / zero reg.
    int         dep  [2] = '{8, 6};
    bit         byp  [2] = '{1'b1, 1'b0};
    bit         zr   [2] = '{1'b0, 1'b1};
    logic [7:0] mm   [2][8];
    int         left [2];
    int         cidx [2];

    register_file_2r1w_if #(.WIDTH(8), .DEPTH(8)) b0 ();
    register_file_2r1w_if #(.WIDTH(8), .DEPTH(6)) b1 ();

    assign b0.we = we;       assign b1.we = we;
    assign b0.waddr = waddr; assign b1.waddr = waddr;
    assign b0.din = din;     assign b1.din = din;
    assign b0.raddr_a = raddr_a; assign b1.raddr_a = raddr_a;
    assign b0.raddr_b = raddr_b; assign b1.raddr_b = raddr_b;
    assign b0.clear = clear; assign b1.clear = clear;

    register_file_2r1w #(.WIDTH(8), .DEPTH(8), .BYPASS(1), .ZERO_REG(0)) dut0 (
        .clk_i (clk), .rst_ni (rst_n), .bus (b0.slave)
    );
    register_file_2r1w #(.WIDTH(8), .DEPTH(6), .BYPASS(0), .ZERO_REG(1)) dut1 (
        .clk_i (clk), .rst_ni (rst_n), .bus (b1.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    function automatic bit acc(int i);
        return we && (left[i] == 0) && !clear && (int'(waddr) < dep[i]) && !(zr[i] && waddr == 3'd0);
    endfunction

    function automatic logic [7:0] mread(int i, logic [2:0] a);
        if (int'(a) >= dep[i] || (zr[i] && a == 3'd0)) return 8'h00;
        if (byp[i] && acc(i) && waddr == a) return din;
        return mm[i][a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 8; j++) mm[i][j] = 8'h00;
            left[i] = 0;
            cidx[i] = 0;
        end
    endtask

    task automatic check_now();
        chk("a0", b0.dout_a, mread(0, raddr_a));
        chk("b0", b0.dout_b, mread(0, raddr_b));
        chk("busy0", {7'd0, b0.busy}, {7'd0, left[0] != 0});
        chk("a1", b1.dout_a, mread(1, raddr_a));
        chk("b1", b1.dout_b, mread(1, raddr_b));
        chk("busy1", {7'd0, b1.busy}, {7'd0, left[1] != 0});
    endtask

    // Check pre-edge outputs, advance the model by one edge, then let the DUT take the edge.
    task automatic tick();
        #1;
        check_now();
        for (int i = 0; i < 2; i++) begin
            if (left[i] > 0) begin
                mm[i][cidx[i]] = 8'h00;
                cidx[i]++;
                left[i]--;
            end else if (clear) begin
                left[i] = dep[i];
                cidx[i] = 0;
            end else if (acc(i)) begin
                mm[i][waddr] = din;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0; we = 1'b0; waddr = 3'd0; din = 8'h00;
        raddr_a = 3'd0; raddr_b = 3'd0; clear = 1'b0;
        model_reset();
        #2;
        for (int k = 0; k < 8; k++) begin
            raddr_a = 3'(k); raddr_b = 3'(7 - k);
            #1;
            check_now();
            chk("rst_a", b0.dout_a, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Fill 1..7 with 11..17, then cross-read.
        for (int k = 1; k < 8; k++) begin
            we = 1'b1; waddr = 3'(k); din = 8'(10 + k); raddr_a = 3'(k); raddr_b = 3'd0;
            tick();
        end
        we = 1'b0;
        for (int k = 1; k < 8; k++) begin
            raddr_a = 3'(k); raddr_b = 3'(8 - k);
            #1;
            check_now();
            chk("wr_rd_a", b0.dout_a, 8'(10 + k));
            chk("wr_rd_b", b0.dout_b, 8'(18 - k));
        end

        // Bypass on instance 0, none on instance 1.
        we = 1'b1; waddr = 3'd3; din = 8'hA5; raddr_a = 3'd3; raddr_b = 3'd3;
        #1;
        chk("byp_on", b0.dout_a, 8'hA5);
        chk("byp_off", b1.dout_a, 8'h0D);
        tick();
        we = 1'b0;
        #1;
        chk("byp_off_after", b1.dout_a, 8'hA5);

        // Zero register and out-of-range address on instance 1.
        we = 1'b1; waddr = 3'd0; din = 8'hFF; raddr_a = 3'd0; raddr_b = 3'd7;
        tick();
        waddr = 3'd7; din = 8'h42;
        tick();
        we = 1'b0;
        #1;
        check_now();
        chk("zero_reg", b1.dout_a, 8'h00);
        chk("oor_read", b1.dout_b, 8'h00);
        chk("no_zero_reg", b0.dout_a, 8'hFF);

        // Fill with 55, then clear together with a write that must lose.
        for (int k = 0; k < 8; k++) begin
            we = 1'b1; waddr = 3'(k); din = 8'h55;
            tick();
        end
        clear = 1'b1; we = 1'b1; waddr = 3'd2; din = 8'h99; raddr_a = 3'd2; raddr_b = 3'd5;
        #1;
        chk("clr_nobyp", b0.dout_a, 8'h55);
        tick();
        clear = 1'b0;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (!b0.busy) break;
            cnt++;
            clear = (c == 3);
            we = 1'b1; waddr = 3'($urandom_range(0, 7)); din = 8'($urandom);
            raddr_a = 3'(c % 8); raddr_b = 3'($urandom_range(0, 7));
            tick();
        end
        clear = 1'b0;
        chk("busy_len", 8'(cnt), 8'd8);
        we = 1'b1; waddr = 3'd4; din = 8'h3C; raddr_a = 3'd4;
        tick();
        we = 1'b0;
        #1;
        chk("post_clr_wr", b0.dout_a, 8'h3C);

        // Reset in the middle of a clear.
        for (int k = 0; k < 8; k++) begin
            we = 1'b1; waddr = 3'(k); din = 8'(8'h20 + k);
            tick();
        end
        we = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0; raddr_a = 3'd6; raddr_b = 3'd1;
        for (int c = 0; c < 3; c++) tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_now();
        chk("rst_mid_a", b0.dout_a, 8'h00);
        chk("rst_mid_busy", {7'd0, b0.busy}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        we = 1'b1; waddr = 3'd5; din = 8'h77; raddr_a = 3'd5;
        tick();
        we = 1'b0;
        #1;
        chk("wr_after_rst", b0.dout_a, 8'h77);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            we = 1'($urandom_range(0, 1));
            waddr = 3'($urandom_range(0, 7));
            din = 8'($urandom);
            raddr_a = 3'($urandom_range(0, 7));
            raddr_b = 3'($urandom_range(0, 7));
            clear = ($urandom_range(0, 31) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
